queen_backtrack_ctrl: RTL and testbench

QUEEN_BACKTRACK_CTRL -- requirements
Module: queen_backtrack_ctrl

---
 rtl/queen_pkg.sv | 18 +
 rtl/queen_conflict.sv | 18 +
 rtl/queen_backtrack_ctrl.sv | 144 ++++++++++++++
 tb/tb_queen_backtrack_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/queen_pkg.sv
// Shared constants, column type and controller state encoding for the 8-queens search.
package queen_pkg;
  localparam int unsigned N_QUEENS = 8;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned ROW_W    = 3;
  localparam int unsigned CNT_W    = 7;

  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_ADVANCE   = 3'd2,
    S_BACKTRACK = 3'd3,
    S_SOLVED    = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;
endpackage

// File: rtl/queen_conflict.sv
// Combinational attack test between two queens: same column or same diagonal.
module queen_conflict
  import queen_pkg::*;
(
  input  col_t             col_a,
  input  col_t             col_b,
  input  logic [ROW_W-1:0] row_diff,
  output logic             conflict
);
  logic [COL_W:0] col_diff;

  // Absolute column distance, widened by one bit so the subtraction never wraps.
  always_comb begin
    if (col_a >= col_b) col_diff = {1'b0, col_a} - {1'b0, col_b};
    else                col_diff = {1'b0, col_b} - {1'b0, col_a};
    conflict = (col_a == col_b) || (col_diff == {1'b0, row_diff});
  end
endmodule

// File: rtl/queen_backtrack_ctrl.sv
// Iterative backtracking 8-queens solver emitting solutions in lexicographic order.
// Optional solution counter output sol_cnt when QUEEN_SOL_COUNT_EN is defined.
module queen_backtrack_ctrl
  import queen_pkg::*;
(
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic             start,
  input  logic             next,
  input  logic [ROW_W-1:0] rd_row,
  output col_t             rd_col,
  output logic             busy,
  output logic             found,
  output logic             no_more
`ifdef QUEEN_SOL_COUNT_EN
  ,
  output logic [CNT_W-1:0] sol_cnt
`endif
);
  localparam col_t             MAX_COL  = col_t'(N_QUEENS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_QUEENS - 1);

  state_t                    state_q, state_d;
  col_t [N_QUEENS-1:0]       col_q, col_d;
  logic [ROW_W-1:0]          row_q, row_d, chk_q, chk_d;
  logic [ROW_W-1:0]          row_inc, row_dec;
  logic                      hit, retry, restart;
  logic                      busy_d, found_d, no_more_d;
`ifdef QUEEN_SOL_COUNT_EN
  logic [CNT_W-1:0]          cnt_q, cnt_d;
`endif

  assign row_inc = row_q + ROW_W'(1);
  assign row_dec = row_q - ROW_W'(1);

  queen_conflict u_conflict (
    .col_a    (col_q[chk_q]),
    .col_b    (col_q[row_q]),
    .row_diff (row_q - chk_q),
    .conflict (hit)
  );

  always_comb rd_col = col_q[rd_row];

  // Next-state and datapath update; a SOLVED resume is treated as a conflict at the last row.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    chk_d   = chk_q;
    restart = start && (state_q == S_IDLE || state_q == S_SOLVED || state_q == S_EXHAUSTED);
    retry   = ((state_q == S_CHECK) && (chk_q != row_q) && hit) ||
              ((state_q == S_SOLVED) && !start && next);

    case (state_q)
      S_CHECK: begin
        if (chk_q == row_q) state_d = S_ADVANCE;
        else if (!hit)      chk_d   = chk_q + ROW_W'(1);
      end
      S_ADVANCE: begin
        if (row_q == LAST_ROW) begin
          state_d = S_SOLVED;
        end else begin
          row_d          = row_inc;
          col_d[row_inc] = '0;
          chk_d          = '0;
          state_d        = S_CHECK;
        end
      end
      S_BACKTRACK: begin
        if (row_q == '0) begin
          state_d = S_EXHAUSTED;
        end else begin
          row_d = row_dec;
          if (col_q[row_dec] != MAX_COL) begin
            col_d[row_dec] = col_q[row_dec] + COL_W'(1);
            chk_d          = '0;
            state_d        = S_CHECK;
          end
        end
      end
      S_IDLE, S_SOLVED, S_EXHAUSTED: ;
      default: state_d = S_IDLE;
    endcase

    if (retry) begin
      if (col_q[row_q] != MAX_COL) begin
        col_d[row_q] = col_q[row_q] + COL_W'(1);
        chk_d        = '0;
        state_d      = S_CHECK;
      end else begin
        state_d = S_BACKTRACK;
      end
    end

    if (restart) begin
      row_d    = '0;
      col_d[0] = '0;
      chk_d    = '0;
      state_d  = S_CHECK;
    end

    busy_d    = (state_d == S_CHECK) || (state_d == S_ADVANCE) || (state_d == S_BACKTRACK);
    found_d   = (state_d == S_SOLVED);
    no_more_d = (state_d == S_EXHAUSTED);

`ifdef QUEEN_SOL_COUNT_EN
    cnt_d = cnt_q;
    if (restart)
      cnt_d = '0;
    else if ((state_q == S_ADVANCE) && (row_q == LAST_ROW) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      chk_q   <= '0;
      busy    <= 1'b0;
      found   <= 1'b0;
      no_more <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      chk_q   <= chk_d;
      busy    <= busy_d;
      found   <= found_d;
      no_more <= no_more_d;
    end
  end

`ifdef QUEEN_SOL_COUNT_EN
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign sol_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_queen_backtrack_ctrl.sv
// Scoreboard bench for queen_backtrack_ctrl; reference boards come from a permutation sweep.
`timescale 1ns/1ps
module tb_queen_backtrack_ctrl;
  logic        clk = 1'b0;
  logic        a_rst_n = 1'b1;
  logic        start = 1'b0;
  logic        next = 1'b0;
  logic [2:0]  rd_row = 3'd0;
  logic [2:0]  rd_col;
  logic        busy, found, no_more;
`ifdef QUEEN_SOL_COUNT_EN
  logic [6:0]  sol_cnt;
`endif

  typedef struct packed {
    logic        is_sol;
    logic [23:0] board;
    logic [6:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] sols[$];
  int          compared = 0;
  int          mismatched = 0;
  int          events_seen = 0;
  int          model_cnt = 0;

  always #10 clk = ~clk;

  queen_backtrack_ctrl dut (
    .clk     (clk),
    .a_rst_n (a_rst_n),
    .start   (start),
    .next    (next),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .busy    (busy),
    .found   (found),
    .no_more (no_more)
`ifdef QUEEN_SOL_COUNT_EN
    ,
    .sol_cnt (sol_cnt)
`endif
  );

  // Every 8-queens board is a permutation of columns; sweeping permutations in
  // lexicographic order and keeping the diagonal-free ones gives the solution order.
  function automatic void build_solutions();
    int p[8];
    int i, j, t, l, r;
    bit ok, done;
    logic [23:0] b;
    for (int k = 0; k < 8; k++) p[k] = k;
    done = 0;
    while (!done) begin
      ok = 1;
      for (int a = 0; a < 8; a++)
        for (int c = a + 1; c < 8; c++)
          if ((p[c] - p[a] == c - a) || (p[a] - p[c] == c - a)) ok = 0;
      if (ok) begin
        b = '0;
        for (int k = 0; k < 8; k++) b[3*k +: 3] = 3'(p[k]);
        sols.push_back(b);
      end
      i = 6;
      while (i >= 0 && p[i] > p[i+1]) i--;
      if (i < 0) begin
        done = 1;
      end else begin
        j = 7;
        while (p[j] < p[i]) j--;
        t = p[i]; p[i] = p[j]; p[j] = t;
        l = i + 1; r = 7;
        while (l < r) begin
          t = p[l]; p[l] = p[r]; p[r] = t;
          l++; r--;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic read_board(output logic [23:0] b);
    b = '0;
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      b[3*r +: 3] = rd_col;
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
  endtask

  task automatic push_sol(input int idx);
    exp_t e;
    model_cnt = (model_cnt >= 127) ? 127 : model_cnt + 1;
    e.is_sol = 1'b1;
    e.board  = sols[idx];
    e.cnt    = 7'(model_cnt);
    exp_q.push_back(e);
  endtask

  task automatic push_end();
    exp_t e;
    e.is_sol = 1'b0;
    e.board  = '0;
    e.cnt    = 7'(model_cnt);
    exp_q.push_back(e);
  endtask

  task automatic pulse(input bit is_start);
    @(negedge clk);
    if (is_start) start = 1'b1;
    else          next  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    next  = 1'b0;
  endtask

  // Waits for the monitor to score an event, injecting stray start/next pulses while busy.
  task automatic wait_event(input int target);
    int cyc;
    cyc = 0;
    while (events_seen < target) begin
      @(negedge clk);
      start = 1'b0;
      next  = 1'b0;
      if (busy && $urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 1) start = 1'b1;
        else                           next  = 1'b1;
      end
      cyc++;
      if (cyc > 20000) begin
        compared++;
        mismatched++;
        $display("FAIL wait_event: timeout with %0d events, required %0d", events_seen, target);
        summary();
        $finish;
      end
    end
    @(negedge clk);
    start = 1'b0;
    next  = 1'b0;
  endtask

  // Monitor: on each rising found/no_more, pop the scoreboard and compare.
  initial begin : monitor
    logic        fp, np;
    logic [23:0] act;
    exp_t        e;
    fp = 1'b0;
    np = 1'b0;
    forever begin
      @(negedge clk);
      if ((found && !fp) || (no_more && !np)) begin
        read_board(act);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_event: found=%0b no_more=%0b with empty scoreboard", found, no_more);
        end else begin
          e = exp_q.pop_front();
          check("found_flag", 32'(found), 32'(e.is_sol));
          check("no_more_flag", 32'(no_more), 32'(!e.is_sol));
          check("busy_at_event", 32'(busy), 32'd0);
          if (e.is_sol) check("board", 32'(act), 32'(e.board));
`ifdef QUEEN_SOL_COUNT_EN
          check("sol_cnt", 32'(sol_cnt), 32'(e.cnt));
`endif
        end
        events_seen++;
      end
      fp = found;
      np = no_more;
    end
  end

  initial begin : stimulus
    logic [23:0] b;
    build_solutions();

    // Power-on reset values
    #1 a_rst_n = 1'b0;
    #4;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_found", 32'(found), 32'd0);
    check("rst_no_more", 32'(no_more), 32'd0);
    read_board(b);
    check("rst_board", 32'(b), 32'd0);
    repeat (2) @(negedge clk);
    a_rst_n = 1'b1;

    // next outside SOLVED is ignored
    pulse(0);
    repeat (5) @(negedge clk);
    check("idle_next_busy", 32'(busy), 32'd0);
    check("idle_next_found", 32'(found), 32'd0);

    // Abort a search with an asynchronous reset mid-cycle
    pulse(1);
    repeat (3) @(negedge clk);
    check("search_busy", 32'(busy), 32'd1);
    #3 a_rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_found", 32'(found), 32'd0);
    check("abort_no_more", 32'(no_more), 32'd0);
    read_board(b);
    check("abort_board", 32'(b), 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_resume_busy", 32'(busy), 32'd0);
    check("no_resume_found", 32'(found), 32'd0);

    // Full enumeration
    model_cnt = 0;
    push_sol(0);
    pulse(1);
    wait_event(1);
    for (int i = 1; i < 92; i++) begin
      push_sol(i);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      pulse(0);
      wait_event(i + 1);
    end
    push_end();
    pulse(0);
    wait_event(93);

    // next in EXHAUSTED is ignored
    pulse(0);
    repeat (5) @(negedge clk);
    check("exh_next_no_more", 32'(no_more), 32'd1);
    check("exh_next_busy", 32'(busy), 32'd0);

    // start from EXHAUSTED, then restart from SOLVED
    model_cnt = 0;
    push_sol(0);
    pulse(1);
    wait_event(94);
    push_sol(1);
    pulse(0);
    wait_event(95);
    model_cnt = 0;
    push_sol(0);
    pulse(1);
    wait_event(96);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    summary();
    $finish;
  end
endmodule
